// File: rtl/vx_branch_resolver.sv
// vx_branch_resolver: per-warp PC/active/stall state, branch resolution from the ALU blocks,
// and round-robin issue of one warp per handshake into a registered fetch output.
module vx_branch_resolver #(
  parameter int NUM_WARPS = 4,
  parameter int NW_WIDTH = 2,
  parameter int NUM_ALU_BLOCKS = 2,
  parameter int PC_BITS = 31,
  parameter logic [PC_BITS-1:0] STARTUP_PC = 31'h2000_0000,
  parameter int PERF_BITS = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_ALU_BLOCKS-1:0] br_valid,
  input  logic [NUM_ALU_BLOCKS*NW_WIDTH-1:0] br_wid,
  input  logic [NUM_ALU_BLOCKS-1:0] br_taken,
  input  logic [NUM_ALU_BLOCKS*PC_BITS-1:0] br_dest,
  input  logic wstart_valid,
  input  logic [NW_WIDTH-1:0] wstart_wid,
  input  logic [PC_BITS-1:0] wstart_pc,
  input  logic wstop_valid,
  input  logic [NW_WIDTH-1:0] wstop_wid,
  input  logic unlock_valid,
  input  logic [NW_WIDTH-1:0] unlock_wid,
  output logic sched_valid,
  input  logic sched_ready,
  output logic [NW_WIDTH-1:0] sched_wid,
  output logic [PC_BITS-1:0] sched_pc,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_taken
);
  logic [NUM_WARPS-1:0] active, stalled, eligible, active_n, stalled_n;
  logic [PC_BITS-1:0] pc [NUM_WARPS];
  logic [PC_BITS-1:0] pc_n [NUM_WARPS];
  logic [NW_WIDTH-1:0] rr, winner, cand;
  logic found, load, hit, issue;
  logic [PC_BITS-1:0] tgt;
  logic [PERF_BITS-1:0] nb, nt;

  assign eligible = active & ~stalled;
  assign load = (~sched_valid | sched_ready) & |eligible;

  always_comb begin
    winner = rr;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = NW_WIDTH'((int'(rr) + i) % NUM_WARPS);
      if (!found && eligible[cand]) begin
        winner = cand;
        found = 1'b1;
      end
    end
  end

  // Per warp, highest priority wins: wstart > branch > issue > unlock; wstop only touches active.
  always_comb begin
    active_n = active;
    stalled_n = stalled;
    pc_n = pc;
    nb = '0;
    nt = '0;
    hit = 1'b0;
    tgt = '0;
    issue = 1'b0;
    for (int b = 0; b < NUM_ALU_BLOCKS; b++) begin
      nb = nb + PERF_BITS'(br_valid[b]);
      nt = nt + PERF_BITS'(br_valid[b] & br_taken[b]);
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      hit = 1'b0;
      tgt = pc[w];
      for (int b = NUM_ALU_BLOCKS - 1; b >= 0; b--)
        if (br_valid[b] && br_wid[b*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)) begin
          hit = 1'b1;
          tgt = br_taken[b] ? br_dest[b*PC_BITS +: PC_BITS] : pc[w];
        end
      issue = load && winner == NW_WIDTH'(w);
      if (wstart_valid && wstart_wid == NW_WIDTH'(w)) begin
        active_n[w] = 1'b1;
        stalled_n[w] = 1'b0;
        pc_n[w] = wstart_pc;
      end else begin
        if (hit) begin
          stalled_n[w] = 1'b0;
          pc_n[w] = tgt;
        end else if (issue) begin
          stalled_n[w] = 1'b1;
          pc_n[w] = pc[w] + PC_BITS'(2);
        end else if (unlock_valid && unlock_wid == NW_WIDTH'(w))
          stalled_n[w] = 1'b0;
        if (wstop_valid && wstop_wid == NW_WIDTH'(w))
          active_n[w] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= NUM_WARPS'(1);
      stalled <= '0;
      for (int w = 0; w < NUM_WARPS; w++)
        pc[w] <= (w == 0) ? STARTUP_PC : '0;
      rr <= '0;
      sched_valid <= 1'b0;
      sched_wid <= '0;
      sched_pc <= '0;
      perf_branches <= '0;
      perf_taken <= '0;
    end else begin
      active <= active_n;
      stalled <= stalled_n;
      pc <= pc_n;
      perf_branches <= perf_branches + nb;
      perf_taken <= perf_taken + nt;
      if (load) begin
        sched_valid <= 1'b1;
        sched_wid <= winner;
        sched_pc <= pc[winner];
        rr <= winner;
      end else if (sched_ready)
        sched_valid <= 1'b0;
    end
  end

  for (genvar a = 0; a < NUM_ALU_BLOCKS; a++) begin : g_chk
    assert property (@(posedge clk) disable iff (reset)
      br_valid[a] |-> stalled[br_wid[a*NW_WIDTH +: NW_WIDTH]]);
    for (genvar c = a + 1; c < NUM_ALU_BLOCKS; c++) begin : g_pair
      assert property (@(posedge clk) disable iff (reset)
        !(br_valid[a] && br_valid[c] &&
          br_wid[a*NW_WIDTH +: NW_WIDTH] == br_wid[c*NW_WIDTH +: NW_WIDTH]));
    end
  end
endmodule

// File: tb/tb_vx_branch_resolver.sv
// tb_vx_branch_resolver: directed vector table for the scheduling/branch scenarios, a reset-mid-hold
// sequence, then legal random traffic checked against an event-ordered reference model.
module tb_vx_branch_resolver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] br_valid = '0;
  logic [3:0] br_wid = '0;
  logic [1:0] br_taken = '0;
  logic [61:0] br_dest = '0;
  logic wstart_valid = 1'b0;
  logic [1:0] wstart_wid = '0;
  logic [30:0] wstart_pc = '0;
  logic wstop_valid = 1'b0;
  logic [1:0] wstop_wid = '0;
  logic unlock_valid = 1'b0;
  logic [1:0] unlock_wid = '0;
  logic sched_valid;
  logic sched_ready = 1'b0;
  logic [1:0] sched_wid;
  logic [30:0] sched_pc;
  logic [31:0] perf_branches, perf_taken;
  int total = 0;
  int bad = 0;

  vx_branch_resolver dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken),
    .br_dest(br_dest), .wstart_valid(wstart_valid), .wstart_wid(wstart_wid),
    .wstart_pc(wstart_pc), .wstop_valid(wstop_valid), .wstop_wid(wstop_wid),
    .unlock_valid(unlock_valid), .unlock_wid(unlock_wid), .sched_valid(sched_valid),
    .sched_ready(sched_ready), .sched_wid(sched_wid), .sched_pc(sched_pc),
    .perf_branches(perf_branches), .perf_taken(perf_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rdy; bit ulv; bit [1:0] ulw; bit wsv; bit [1:0] wsw; bit [30:0] wspc;
    bit [1:0] bv; bit [3:0] bw; bit [1:0] bt; bit [30:0] bd0; bit [30:0] bd1;
    bit ev; bit [1:0] ew; bit [30:0] epc; int enb; int ent;
  } vec_t;
  vec_t vt [17];

  bit m_act [4];
  bit m_stl [4];
  logic [30:0] m_pc [4];
  int m_rr;
  bit m_v;
  logic [1:0] m_w;
  logic [30:0] m_out;
  bit [31:0] m_nb, m_nt;
  bit use_model = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_act[k] = (k == 0);
      m_stl[k] = 1'b0;
      m_pc[k] = (k == 0) ? 31'h2000_0000 : 31'h0;
    end
    m_rr = 0; m_v = 0; m_w = 0; m_out = 0; m_nb = 0; m_nt = 0;
  endtask

  // Effects applied lowest priority first so that later (higher priority) ones overwrite.
  task automatic model_step();
    logic [30:0] opc [4];
    int win, c, w;
    opc = m_pc;
    win = -1;
    if (!m_v || sched_ready) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_rr + k) % 4;
        if (win < 0 && m_act[c] && !m_stl[c]) win = c;
      end
      if (win >= 0) begin
        m_v = 1; m_w = 2'(win); m_out = opc[win]; m_rr = win;
      end else m_v = 0;
    end
    if (wstop_valid) m_act[wstop_wid] = 0;
    if (unlock_valid) m_stl[unlock_wid] = 0;
    if (win >= 0) begin
      m_stl[win] = 1;
      m_pc[win] = opc[win] + 31'd2;
    end
    for (int b = 1; b >= 0; b--)
      if (br_valid[b]) begin
        w = int'(br_wid[b*2 +: 2]);
        m_stl[w] = 0;
        m_pc[w] = br_taken[b] ? br_dest[b*31 +: 31] : opc[w];
        m_nb++;
        if (br_taken[b]) m_nt++;
      end
    if (wstart_valid) begin
      m_act[wstart_wid] = 1; m_stl[wstart_wid] = 0; m_pc[wstart_wid] = wstart_pc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    #1;
  endtask

  task automatic drive(vec_t t);
    sched_ready = t.rdy; unlock_valid = t.ulv; unlock_wid = t.ulw;
    wstart_valid = t.wsv; wstart_wid = t.wsw; wstart_pc = t.wspc;
    wstop_valid = 1'b0; wstop_wid = '0;
    br_valid = t.bv; br_wid = t.bw; br_taken = t.bt; br_dest = {t.bd1, t.bd0};
  endtask

  task automatic chk_out(string tag, bit v, logic [1:0] w, logic [30:0] p, int nb, int nt);
    chk({tag, " valid"}, 64'(sched_valid), 64'(v));
    chk({tag, " wid"}, 64'(sched_wid), 64'(w));
    chk({tag, " pc"}, 64'(sched_pc), 64'(p));
    chk({tag, " branches"}, 64'(perf_branches), 64'(nb));
    chk({tag, " taken"}, 64'(perf_taken), 64'(nt));
  endtask

  initial begin
    vt[0]  = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,0,31'h2000_0000,0,0};
    vt[1]  = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  0,0,31'h2000_0000,0,0};
    vt[2]  = '{1,1,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  0,0,31'h2000_0000,0,0};
    vt[3]  = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,0,31'h2000_0002,0,0};
    vt[4]  = '{1,0,0,1,1,31'h100,2'b00,4'b0000,2'b00,31'h0,  31'h0,  0,0,31'h2000_0002,0,0};
    vt[5]  = '{1,1,0,1,2,31'h200,2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,1,31'h100,0,0};
    vt[6]  = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,2,31'h200,0,0};
    vt[7]  = '{1,0,0,0,0,31'h0,  2'b10,4'b0100,2'b10,31'h0,  31'h80, 1,0,31'h2000_0004,1,1};
    vt[8]  = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,1,31'h80,1,1};
    vt[9]  = '{1,0,0,0,0,31'h0,  2'b01,4'b0001,2'b00,31'h40, 31'h0,  0,1,31'h80,2,1};
    vt[10] = '{1,0,0,0,0,31'h0,  2'b11,4'b1000,2'b01,31'h300,31'h0,  1,1,31'h82,4,2};
    vt[11] = '{1,0,0,0,0,31'h0,  2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,2,31'h202,4,2};
    for (int i = 12; i < 17; i++)
      vt[i] = '{0,0,0,0,0,31'h0, 2'b00,4'b0000,2'b00,31'h0,  31'h0,  1,2,31'h202,4,2};

    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 31'h0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(vt[i]);
      tick();
      chk_out($sformatf("row%0d", i), vt[i].ev, vt[i].ew, vt[i].epc, vt[i].enb, vt[i].ent);
    end

    #2 reset = 1'b1;
    #1 chk_out("async_reset", 0, 0, 31'h0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    sched_ready = 1'b1;
    tick();
    chk_out("post_reset_issue", 1, 0, 31'h2000_0000, 0, 0);
    tick();
    chk_out("post_reset_idle", 0, 0, 31'h2000_0000, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    use_model = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] w0, w1;
      sched_ready = ($urandom_range(0, 3) != 0);
      wstart_valid = ($urandom_range(0, 7) == 0);
      wstart_wid = 2'($urandom_range(0, 3));
      wstart_pc = 31'($urandom);
      wstop_valid = ($urandom_range(0, 9) == 0);
      wstop_wid = 2'($urandom_range(0, 3));
      unlock_valid = ($urandom_range(0, 1) == 0);
      unlock_wid = 2'($urandom_range(0, 3));
      w0 = 2'($urandom_range(0, 3));
      w1 = 2'($urandom_range(0, 3));
      br_valid[0] = m_stl[w0] && ($urandom_range(0, 1) == 0);
      br_valid[1] = m_stl[w1] && ($urandom_range(0, 1) == 0) && !(br_valid[0] && w0 == w1);
      br_wid = {w1, w0};
      br_taken = 2'($urandom_range(0, 3));
      br_dest = {31'($urandom), 31'($urandom)};
      tick();
      chk_out($sformatf("rand%0d", n), m_v, m_w, m_out, int'(m_nb), int'(m_nt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
